// File: rtl/ram_read_streamer_pkg.sv
// ram_read_streamer_pkg: FSM encoding and configuration legality for the RAM read streamer
package ram_read_streamer_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_FINISH} state_t;
  function automatic bit cfg_ok(input int rd_latency, input int fifo_depth);
    return (rd_latency == 0 || rd_latency == 1) && fifo_depth >= rd_latency + 1;
  endfunction
endpackage

// File: rtl/ram_read_streamer_if.sv
// ram_read_streamer_if: command, RAM read port and output stream bundle of the read streamer
interface ram_read_streamer_if #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 12,
  parameter int COUNT_WIDTH = 16
) ();
  logic cmd_valid;
  logic cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_base;
  logic [COUNT_WIDTH-1:0] cmd_count;
  logic [ADDR_WIDTH-1:0] cmd_stride;
  logic mem_read_req;
  logic [ADDR_WIDTH-1:0] mem_read_addr;
  logic [DATA_WIDTH-1:0] mem_read_data;
  logic m_valid;
  logic m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic m_last;
  logic busy;
  logic done;
  modport master (
    input cmd_valid, cmd_base, cmd_count, cmd_stride, mem_read_data, m_ready,
    output cmd_ready, mem_read_req, mem_read_addr, m_valid, m_data, m_last, busy, done
  );
  modport slave (
    output cmd_valid, cmd_base, cmd_count, cmd_stride, mem_read_data, m_ready,
    input cmd_ready, mem_read_req, mem_read_addr, m_valid, m_data, m_last, busy, done
  );
endinterface

// File: rtl/ram_read_streamer_stream_fifo.sv
// stream_fifo: register-based circular return buffer with occupancy count
module stream_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic o_full,
  output logic o_empty
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr <= nxt(r_wr);
      end
      if (i_pop) r_rd <= nxt(r_rd);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end
  assign o_data = r_mem[r_rd];
  assign o_count = r_count;
  assign o_full = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;
endmodule

// File: rtl/ram_read_streamer.sv
// ram_read_streamer: turns (base, count, stride) commands into RAM reads and a valid/ready stream
module ram_read_streamer
  import ram_read_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 12,
  parameter int COUNT_WIDTH = 16,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 2
) (
  input logic clk,
  input logic reset_n,
  ram_read_streamer_if.master bus
);
  localparam int FW = $clog2(FIFO_DEPTH + 1);
  if (!cfg_ok(RD_LATENCY, FIFO_DEPTH)) begin : g_bad_cfg
    $error("ram_read_streamer: RD_LATENCY must be 0 or 1 and FIFO_DEPTH >= RD_LATENCY+1");
  end
  state_t r_state;
  logic [ADDR_WIDTH-1:0] r_addr, r_stride;
  logic [COUNT_WIDTH-1:0] r_issue_left;
  logic r_busy, r_done, r_cmd_ready, r_inflight, r_inflight_last;
  logic w_issue, w_issue_last, w_push, w_pop, w_full, w_empty;
  logic [FW-1:0] w_fifo_count;
  logic [FW:0] w_used;
  logic [DATA_WIDTH:0] w_push_word, w_head;
  assign w_pop = !w_empty && bus.m_ready;
  // the word leaving this cycle frees its slot, so full-rate streaming fits in FIFO_DEPTH=2
  assign w_used = {1'b0, w_fifo_count} + (FW+1)'(r_inflight) - (FW+1)'(w_pop);
  assign w_issue = r_state == ST_ISSUE && r_issue_left != '0 && w_used < (FW+1)'(FIFO_DEPTH);
  assign w_issue_last = r_issue_left == COUNT_WIDTH'(1);
  assign w_push = RD_LATENCY == 0 ? w_issue : r_inflight;
  assign w_push_word = {RD_LATENCY == 0 ? w_issue_last : r_inflight_last, bus.mem_read_data};
  stream_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .i_push(w_push && (!w_full || w_pop)),
    .i_data(w_push_word),
    .i_pop(w_pop),
    .o_data(w_head),
    .o_count(w_fifo_count),
    .o_full(w_full),
    .o_empty(w_empty)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_addr <= '0;
      r_stride <= '0;
      r_issue_left <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_inflight <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight <= RD_LATENCY != 0 && w_issue;
      r_inflight_last <= w_issue_last;
      if (w_issue) begin
        r_addr <= r_addr + r_stride;
        r_issue_left <= r_issue_left - 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (!r_cmd_ready) r_cmd_ready <= 1'b1;
          else if (bus.cmd_valid) begin
            r_cmd_ready <= 1'b0;
            r_busy <= 1'b1;
            r_addr <= bus.cmd_base;
            r_stride <= bus.cmd_stride;
            r_issue_left <= bus.cmd_count;
            r_state <= bus.cmd_count == '0 ? ST_FINISH : ST_ISSUE;
          end
        end
        ST_ISSUE: if (w_issue && w_issue_last) r_state <= ST_DRAIN;
        ST_DRAIN: begin
          if (w_pop && w_head[DATA_WIDTH]) begin
            r_state <= ST_FINISH;
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        ST_FINISH: begin
          if (r_done) begin
            r_done <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  assign bus.cmd_ready = r_cmd_ready;
  assign bus.mem_read_req = w_issue;
  assign bus.mem_read_addr = r_addr;
  assign bus.m_valid = !w_empty;
  assign bus.m_data = w_head[DATA_WIDTH-1:0];
  assign bus.m_last = w_head[DATA_WIDTH];
  assign bus.busy = r_busy;
  assign bus.done = r_done;
endmodule

// File: tb/tb_ram_read_streamer.sv
// tb_ram_read_streamer: directed self-checking bench for registered- and combinational-read builds
module tb_ram_read_streamer;
  localparam int DW = 10, AW = 12, CW = 16;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int cyc = 0;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  ram_read_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) bus ();
  ram_read_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) bus0 ();
  ram_read_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .RD_LATENCY(1), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  ram_read_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .RD_LATENCY(0), .FIFO_DEPTH(2)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );
  // RAM contents: mem[a] = a (low DW bits); one registered and one combinational read port
  always @(posedge clk) if (bus.mem_read_req) bus.mem_read_data <= bus.mem_read_addr[DW-1:0];
  assign bus0.mem_read_data = bus0.mem_read_addr[DW-1:0];
  logic [DW-1:0] q_data[$];
  logic q_last[$];
  int q_cyc[$];
  logic [AW-1:0] q_addr[$];
  int req_cnt = 0, valid_cnt = 0, done_cnt = 0, done_cyc = -1;
  int out_cnt = 0, max_out = 0, stab_err = 0, full_push_err = 0;
  logic p_hold = 1'b0;
  logic [DW:0] p_word = '0;
  always @(negedge clk) begin
    if (!reset_n) begin
      out_cnt = 0;
      p_hold = 1'b0;
    end else begin
      if (bus.mem_read_req) begin
        req_cnt++;
        out_cnt++;
        q_addr.push_back(bus.mem_read_addr);
      end
      if (bus.m_valid) valid_cnt++;
      if (p_hold && !(bus.m_valid && {bus.m_last, bus.m_data} == p_word)) stab_err++;
      if (bus.m_valid && bus.m_ready) begin
        q_data.push_back(bus.m_data);
        q_last.push_back(bus.m_last);
        q_cyc.push_back(cyc);
        out_cnt--;
      end
      if (out_cnt > max_out) max_out = out_cnt;
      p_hold = bus.m_valid && !bus.m_ready;
      p_word = {bus.m_last, bus.m_data};
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (dut.w_push && dut.u_fifo.o_full && !dut.w_pop) full_push_err++;
    end
  end
  int r0_first = -1, v0_first = -1, d0_cnt = 0;
  logic [DW:0] q0[$];
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus0.mem_read_req && r0_first < 0) r0_first = cyc;
      if (bus0.m_valid && v0_first < 0) v0_first = cyc;
      if (bus0.m_valid && bus0.m_ready) q0.push_back({bus0.m_last, bus0.m_data});
      if (bus0.done) d0_cnt++;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic issue_cmd(input logic [AW-1:0] base, input logic [CW-1:0] cnt, input logic [AW-1:0] stride,
                           output int acc);
    acc = -1;
    bus.cmd_base = base;
    bus.cmd_count = cnt;
    bus.cmd_stride = stride;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) check("cmd_accept_timeout", 0, 1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask
  task automatic run_to_done(input logic [5:0] pat, input int plen);
    bit seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      bus.m_ready = pat[k % plen];
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!seen) check("done_timeout", 0, 1);
    @(posedge clk);
    #1 bus.m_ready = 1'b1;
  endtask
  task automatic chk_stream(input string tag, input int b, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                            input int n);
    logic [AW-1:0] a;
    a = base;
    check({tag, "_words"}, q_data.size() - b, n);
    for (int i = 0; i < n && b + i < q_data.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), q_data[b+i], a[DW-1:0]);
      check($sformatf("%s_last%0d", tag, i), q_last[b+i], i == n - 1);
      a = a + stride;
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int acc, acc2, b, ra, r0, v0, d0, acc0;
    bus.cmd_valid = 1'b0;
    bus.cmd_base = '0;
    bus.cmd_count = '0;
    bus.cmd_stride = '0;
    bus.m_ready = 1'b1;
    bus0.cmd_valid = 1'b0;
    bus0.cmd_base = '0;
    bus0.cmd_count = '0;
    bus0.cmd_stride = '0;
    bus0.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_req", bus.mem_read_req, 0);
    check("rst_addr", bus.mem_read_addr, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_m_last", bus.m_last, 0);
    reset_n = 1'b1;
    b = q_data.size();
    d0 = done_cnt;
    issue_cmd(12'h010, 4, 1, acc);
    run_to_done(6'h3f, 6);
    chk_stream("basic", b, 12'h010, 12'h001, 4);
    check("basic_first_lat", (q_cyc.size() > b) ? q_cyc[b] - acc : -1, 3);
    check("basic_back_to_back", (q_cyc.size() > b + 3) ? q_cyc[b+3] - q_cyc[b] : -1, 3);
    check("basic_done_cyc", done_cyc - ((q_cyc.size() > b + 3) ? q_cyc[b+3] : 0), 1);
    check("basic_done_once", done_cnt - d0, 1);
    ra = q_addr.size();
    b = q_data.size();
    issue_cmd(12'hFFE, 3, 3, acc);
    run_to_done(6'h3f, 6);
    check("wrap_nreq", q_addr.size() - ra, 3);
    check("wrap_addr0", (q_addr.size() > ra) ? q_addr[ra] : '1, 12'hFFE);
    check("wrap_addr1", (q_addr.size() > ra + 1) ? q_addr[ra+1] : '1, 12'h001);
    check("wrap_addr2", (q_addr.size() > ra + 2) ? q_addr[ra+2] : '1, 12'h004);
    check("wrap_data0", (q_data.size() > b) ? q_data[b] : '1, 10'h3FE);
    check("wrap_data1", (q_data.size() > b + 1) ? q_data[b+1] : '1, 10'h001);
    check("wrap_data2", (q_data.size() > b + 2) ? q_data[b+2] : '1, 10'h004);
    b = q_data.size();
    issue_cmd(12'h040, 8, 1, acc);
    run_to_done(6'b101001, 6);
    chk_stream("bp", b, 12'h040, 12'h001, 8);
    r0 = req_cnt;
    v0 = valid_cnt;
    d0 = done_cnt;
    issue_cmd(12'h000, 0, 1, acc);
    issue_cmd(12'h020, 1, 1, acc2);
    check("zero_done_lat", done_cyc - acc, 2);
    check("zero_no_req", req_cnt - r0, 0);
    check("zero_no_valid", valid_cnt - v0, 0);
    check("busy_accept_after_done", acc2 - done_cyc, 1);
    b = q_data.size();
    run_to_done(6'h3f, 6);
    chk_stream("after_zero", b, 12'h020, 12'h001, 1);
    check("zero_two_dones", done_cnt - d0, 2);
    b = q_data.size();
    issue_cmd(12'h100, 10, 1, acc);
    for (int i = 0; i < 100 && q_data.size() - b < 3; i++) @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_m_valid", bus.m_valid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_fifo_empty", dut.u_fifo.o_empty, 1);
    check("midrst_cmd_ready", bus.cmd_ready, 0);
    reset_n = 1'b1;
    b = q_data.size();
    issue_cmd(12'h200, 2, 1, acc);
    run_to_done(6'h3f, 6);
    chk_stream("post_rst", b, 12'h200, 12'h001, 2);
    acc0 = -1;
    bus0.cmd_base = 12'h010;
    bus0.cmd_count = 4;
    bus0.cmd_stride = 12'h001;
    bus0.cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus0.cmd_ready) begin
        acc0 = cyc;
        break;
      end
    end
    @(posedge clk);
    #1 bus0.cmd_valid = 1'b0;
    for (int i = 0; i < 100 && d0_cnt == 0; i++) @(negedge clk);
    check("lat0_accepted", acc0 >= 0, 1);
    check("lat0_req_lat", r0_first - acc0, 1);
    check("lat0_valid_lat", v0_first - r0_first, 1);
    check("lat0_words", q0.size(), 4);
    for (int i = 0; i < 4 && i < q0.size(); i++)
      check($sformatf("lat0_word%0d", i), q0[i], {i == 3, 10'(12'h010 + i)});
    check("lat0_done_once", d0_cnt, 1);
    check("max_outstanding_le_2", max_out <= 2, 1);
    check("stream_stable", stab_err, 0);
    check("no_push_when_full", full_push_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
